// File: rtl/pong_pkg.sv
// pong_pkg: shared phase, winner and serve-direction encodings for the Pong datapath.
package pong_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_SERVE = 3'd1,
        PH_PLAY  = 3'd2,
        PH_POINT = 3'd3,
        PH_OVER  = 3'd4,
        PH_PAUSE = 3'd5
    } phase_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic TOWARD_P2 = 1'b0;
    localparam logic TOWARD_P1 = 1'b1;

endpackage

// File: rtl/match_controller_if.sv
// match_controller_if: game-control bus between button/engine sources and the match sequencer.
// Inputs to the controller: start, frame_tick, miss1, miss2.
// Outputs from the controller: ball_run, ball_reset, serve_dir, score1, score2,
// speed_level, timer_run, winner, phase.
// master = source/consumer side, slave = match_controller.
interface match_controller_if;

    logic       start;
    logic       frame_tick;
    logic       miss1;
    logic       miss2;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] speed_level;
    logic       timer_run;
    logic [1:0] winner;
    logic [2:0] phase;

    modport master (
        output start, frame_tick, miss1, miss2,
        input  ball_run, ball_reset, serve_dir, score1, score2,
               speed_level, timer_run, winner, phase
    );

    modport slave (
        input  start, frame_tick, miss1, miss2,
        output ball_run, ball_reset, serve_dir, score1, score2,
               speed_level, timer_run, winner, phase
    );

endinterface

// File: rtl/start_edge_detect.sv
// start_edge_detect: registered rising-edge detector for the start button.
// Ports: clk, rst (sync, active-low), d_i (button level), rise_o (d_i & ~previous d_i).
// The history register resets to 1 so a button held through reset gives no edge.
module start_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst) d_q <= 1'b1;
        else      d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/match_controller.sv
// match_controller: Pong game-phase sequencer (serve, play, scoring, speed-up, match end).
// Ports: clk, rst (sync, active-low), mc (match_controller_if.slave: start, frame_tick,
// miss1, miss2 in; ball_run, ball_reset, serve_dir, score1, score2, speed_level,
// timer_run, winner, phase out). All outputs are registered.
// Optional feature: define MATCH_CTRL_PAUSE_EN to let start toggle PLAY <-> PAUSE.
module match_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 5,
    parameter int SERVE_DELAY = 50,
    parameter int SPEED_STEP  = 500
) (
    input  logic               clk,
    input  logic               rst,
    match_controller_if.slave  mc
);

    localparam int SCW = $clog2(SERVE_DELAY + 1);
    localparam int SPW = $clog2(SPEED_STEP + 1);

    logic           start_rise;
    phase_t         phase_q;
    logic [SCW-1:0] serve_cnt_q;
    logic [SPW-1:0] speed_cnt_q;
    logic [3:0]     score1_q, score2_q;
    logic [1:0]     speed_level_q, winner_q;
    logic           ball_run_q, ball_reset_q, serve_dir_q, timer_run_q;

    start_edge_detect u_start_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (mc.start),
        .rise_o (start_rise)
    );

    // ball_run/timer_run are set on each transition so they line up with phase_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q       <= PH_IDLE;
            serve_cnt_q   <= '0;
            speed_cnt_q   <= '0;
            score1_q      <= '0;
            score2_q      <= '0;
            speed_level_q <= '0;
            winner_q      <= WIN_NONE;
            ball_run_q    <= 1'b0;
            ball_reset_q  <= 1'b0;
            serve_dir_q   <= TOWARD_P2;
            timer_run_q   <= 1'b0;
        end else begin
            ball_reset_q <= 1'b0;
            case (phase_q)
                PH_IDLE, PH_OVER: begin
                    if (start_rise) begin
                        score1_q     <= '0;
                        score2_q     <= '0;
                        winner_q     <= WIN_NONE;
                        serve_dir_q  <= TOWARD_P2;
                        ball_reset_q <= 1'b1;
                        timer_run_q  <= 1'b1;
                        phase_q      <= PH_SERVE;
                    end
                end
                PH_SERVE: begin
                    if (mc.frame_tick) begin
                        if (serve_cnt_q == SCW'(SERVE_DELAY - 1)) begin
                            serve_cnt_q <= '0;
                            ball_run_q  <= 1'b1;
                            phase_q     <= PH_PLAY;
                        end else begin
                            serve_cnt_q <= serve_cnt_q + 1'b1;
                        end
                    end
                end
                PH_PLAY: begin
`ifdef MATCH_CTRL_PAUSE_EN
                    if (start_rise) begin
                        ball_run_q  <= 1'b0;
                        timer_run_q <= 1'b0;
                        phase_q     <= PH_PAUSE;
                    end else
`endif
                    begin
                        if (mc.frame_tick) begin
                            speed_cnt_q <= (speed_cnt_q == SPW'(SPEED_STEP - 1)) ? '0 : speed_cnt_q + 1'b1;
                            if (speed_cnt_q == SPW'(SPEED_STEP - 1) && speed_level_q != 2'd3)
                                speed_level_q <= speed_level_q + 2'd1;
                        end
                        if (mc.miss1 || mc.miss2) begin
                            ball_run_q <= 1'b0;
                            phase_q    <= PH_POINT;
                        end
                        // A simultaneous double miss is a void rally: no score, serve unchanged.
                        if (mc.miss1 && !mc.miss2) begin
                            score2_q    <= score2_q + 4'd1;
                            serve_dir_q <= TOWARD_P1;
                        end
                        if (mc.miss2 && !mc.miss1) begin
                            score1_q    <= score1_q + 4'd1;
                            serve_dir_q <= TOWARD_P2;
                        end
                    end
                end
                PH_POINT: begin
                    if (score1_q == 4'(WIN_SCORE)) begin
                        winner_q    <= WIN_P1;
                        timer_run_q <= 1'b0;
                        phase_q     <= PH_OVER;
                    end else if (score2_q == 4'(WIN_SCORE)) begin
                        winner_q    <= WIN_P2;
                        timer_run_q <= 1'b0;
                        phase_q     <= PH_OVER;
                    end else begin
                        ball_reset_q  <= 1'b1;
                        speed_level_q <= '0;
                        speed_cnt_q   <= '0;
                        phase_q       <= PH_SERVE;
                    end
                end
`ifdef MATCH_CTRL_PAUSE_EN
                PH_PAUSE: begin
                    if (start_rise) begin
                        ball_run_q  <= 1'b1;
                        timer_run_q <= 1'b1;
                        phase_q     <= PH_PLAY;
                    end
                end
`endif
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

    assign mc.ball_run    = ball_run_q;
    assign mc.ball_reset  = ball_reset_q;
    assign mc.serve_dir   = serve_dir_q;
    assign mc.score1      = score1_q;
    assign mc.score2      = score2_q;
    assign mc.speed_level = speed_level_q;
    assign mc.timer_run   = timer_run_q;
    assign mc.winner      = winner_q;
    assign mc.phase       = phase_q;

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: scoreboard bench for match_controller against a behavioural match model.
module tb_match_controller;

    localparam int WS = 5;
    localparam int SD = 50;
    localparam int SS = 500;

    typedef struct packed {
        logic       run;
        logic       brst;
        logic       sdir;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] spd;
        logic       trun;
        logic [1:0] win;
        logic [2:0] ph;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    match_controller_if mc ();

    match_controller #(.WIN_SCORE(WS), .SERVE_DELAY(SD), .SPEED_STEP(SS)) dut (
        .clk (clk),
        .rst (rst),
        .mc  (mc)
    );

    snap_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Model state: phase number (0 idle,1 serve,2 play,3 point,4 over,5 pause),
    // scores, serve direction, speed level, winner, tick counters, button history.
    int m_ph = 0, m_s1 = 0, m_s2 = 0, m_dir = 0, m_spd = 0, m_win = 0;
    int m_serve_ticks = 0, m_play_ticks = 0;
    bit m_prev = 1'b1, m_brst = 1'b0;
    bit st_lvl = 1'b0;

    task automatic model(input bit rn, input bit st, input bit ft, input bit m1, input bit m2);
        bit rise;
        if (!rn) begin
            m_ph = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_spd = 0; m_win = 0;
            m_serve_ticks = 0; m_play_ticks = 0; m_prev = 1'b1; m_brst = 1'b0;
            return;
        end
        rise   = st && !m_prev;
        m_prev = st;
        m_brst = 1'b0;
        if ((m_ph == 0 || m_ph == 4) && rise) begin
            m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_brst = 1'b1; m_ph = 1;
        end else if (m_ph == 1) begin
            if (ft) m_serve_ticks++;
            if (m_serve_ticks == SD) begin
                m_serve_ticks = 0;
                m_ph = 2;
            end
        end else if (m_ph == 2) begin
`ifdef MATCH_CTRL_PAUSE_EN
            if (rise) m_ph = 5; else
`endif
            begin
                if (ft) m_play_ticks++;
                if (m_play_ticks == SS) begin
                    m_play_ticks = 0;
                    if (m_spd < 3) m_spd++;
                end
                if (m1 || m2) m_ph = 3;
                if (m1 && !m2) begin m_s2++; m_dir = 1; end
                if (m2 && !m1) begin m_s1++; m_dir = 0; end
            end
        end else if (m_ph == 3) begin
            if (m_s1 == WS) begin m_win = 1; m_ph = 4; end
            else if (m_s2 == WS) begin m_win = 2; m_ph = 4; end
            else begin m_brst = 1'b1; m_spd = 0; m_play_ticks = 0; m_ph = 1; end
        end else if (m_ph == 5 && rise) begin
            m_ph = 2;
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.run  = (m_ph == 2);
        s.brst = m_brst;
        s.sdir = m_dir[0];
        s.s1   = 4'(m_s1);
        s.s2   = 4'(m_s2);
        s.spd  = 2'(m_spd);
        s.trun = (m_ph >= 1 && m_ph <= 3);
        s.win  = 2'(m_win);
        s.ph   = 3'(m_ph);
        return s;
    endfunction

    task automatic cyc(input bit rn, input bit st, input bit ft, input bit m1, input bit m2);
        @(negedge clk);
        rst           = rn;
        mc.start      = st;
        mc.frame_tick = ft;
        mc.miss1      = m1;
        mc.miss2      = m2;
        model(rn, st, ft, m1, m2);
        exp_q.push_back(model_snap());
    endtask

    task automatic press();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
    endtask

    // Tick (every other cycle) until the model says the ball is in play.
    task automatic to_play();
        for (int n = 0; n < 400 && m_ph == 1; n++) cyc(1, 0, n[0], 0, 0);
        if (m_ph == 1) begin
            errors++;
            $display("FAIL to_play bound: model phase=%0d required=2", m_ph);
        end
    endtask

    task automatic settle_point();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        snap_t e, a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{mc.ball_run, mc.ball_reset, mc.serve_dir, mc.score1, mc.score2,
                  mc.speed_level, mc.timer_run, mc.winner, mc.phase};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual run=%b brst=%b dir=%b s1=%0d s2=%0d spd=%0d trun=%b win=%0d ph=%0d required run=%b brst=%b dir=%b s1=%0d s2=%0d spd=%0d trun=%b win=%0d ph=%0d",
                         $time, a.run, a.brst, a.sdir, a.s1, a.s2, a.spd, a.trun, a.win, a.ph,
                         e.run, e.brst, e.sdir, e.s1, e.s2, e.spd, e.trun, e.win, e.ph);
            end
        end
    end

    initial begin
        mc.start = 1'b0; mc.frame_tick = 1'b0; mc.miss1 = 1'b0; mc.miss2 = 1'b0;
        // Button held through and after reset must not start a match.
        repeat (3) cyc(0, 1, 0, 0, 0);
        repeat (5) cyc(1, 1, 1, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
        // Start, full serve, then long rally to saturate speed.
        press();
        to_play();
        repeat (1600) cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1);
        settle_point();
        to_play();
        // Void rally.
        cyc(1, 0, 0, 1, 1);
        settle_point();
        to_play();
        // Player 2 wins with five points.
        for (int i = 0; i < 8 && m_ph != 4; i++) begin
            cyc(1, 0, 1, 1, 0);
            settle_point();
            to_play();
        end
        repeat (4) cyc(1, 0, 1, 1, 1);
        cyc(1, 0, 0, 0, 1);
        press();
        to_play();
        // Reset mid-play abandons the match.
        repeat (5) cyc(1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
`ifdef MATCH_CTRL_PAUSE_EN
        press();
        to_play();
        press();
        cyc(1, 0, 1, 1, 0);
        repeat (3) cyc(1, 0, 1, 0, 0);
        press();
        repeat (3) cyc(1, 0, 1, 0, 0);
`endif
        // Random traffic.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 24) == 0) st_lvl = ~st_lvl;
            cyc($urandom_range(0, 2999) != 0, st_lvl, 1'($urandom_range(0, 1)),
                $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
